// File: rtl/spsram_access_ctrl_if.sv
// Request/response channel bundle for spsram_access_ctrl.
// master: the bus adapter side (issues requests, consumes read data).
// slave : the controller side.
interface spsram_access_ctrl_if #(
  parameter int ADDR_WIDTH = 21,
  parameter int DATA_WIDTH = 128
);
  localparam int BE_W = DATA_WIDTH / 8;

  logic                  req_vld;
  logic                  req_rdy;
  logic                  req_wr;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [BE_W-1:0]       req_be;
  logic                  rsp_vld;
  logic                  rsp_rdy;
  logic [DATA_WIDTH-1:0] rsp_data;

  modport master (
    output req_vld, req_wr, req_addr, req_wdata, req_be, rsp_rdy,
    input  req_rdy, rsp_vld, rsp_data
  );

  modport slave (
    input  req_vld, req_wr, req_addr, req_wdata, req_be, rsp_rdy,
    output req_rdy, rsp_vld, rsp_data
  );
endinterface

// File: rtl/spsram_access_ctrl.sv
// Single-port byte-lane SRAM initiator. Requests are turned into CEN/WEN
// strobes in the accept cycle; read data comes back through a credit-protected
// response FIFO so the consumer may stall without losing data.
// Optional feature macro: SPSRAM_CTRL_INIT_EN -- zero-fills the whole array
// after reset before any request is accepted.
module spsram_access_ctrl #(
  parameter int ADDR_WIDTH = 21,
  parameter int DATA_WIDTH = 128,
  parameter int RSP_DEPTH  = 2
) (
  input  logic                      CLK,
  input  logic                      RST,
  spsram_access_ctrl_if.slave       bus,
  output logic [ADDR_WIDTH-1:0]     sram_a,
  output logic                      sram_cen,
  output logic [DATA_WIDTH/8-1:0]   sram_wen,
  output logic [DATA_WIDTH-1:0]     sram_d,
  input  logic [DATA_WIDTH-1:0]     sram_q,
  output logic                      init_done
);
  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(RSP_DEPTH);

  logic                  run;
  logic                  acc_p0;
  logic                  rd_acc_p0;
  logic                  rd_vld_p1;
  logic                  pop;
  logic [CNT_W:0]        credit_used;
  logic [CNT_W-1:0]      fifo_cnt;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [DATA_WIDTH-1:0] fifo_mem [RSP_DEPTH];

`ifdef SPSRAM_CTRL_INIT_EN
  typedef enum logic [1:0] {IDLE_RST, INIT, RUN} state_t;
  state_t                state;
  state_t                state_nxt;
  logic                  init_wr;
  logic [ADDR_WIDTH-1:0] init_addr;

  // State register for the post-reset zero-fill sequence.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE_RST;
    else     state <= state_nxt;
  end

  // Zero-fill walks every address once; its wrap back to 0 ends INIT.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                init_addr <= '0;
    else if (state == INIT) init_addr <= init_addr + 1'b1;
  end

  // Next-state: one idle cycle after reset, fill, then run forever.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE_RST: state_nxt = INIT;
      INIT:     if (&init_addr) state_nxt = RUN;
      RUN:      state_nxt = RUN;
      default:  state_nxt = IDLE_RST;
    endcase
  end

  // State outputs: fill strobes in INIT, traffic only in RUN.
  always_comb begin
    init_wr = (state == INIT);
    run     = (state == RUN);
  end
`else
  assign run = 1'b1;
`endif

  assign init_done = run;

  // ---- p0: request accept and SRAM strobes ----
  // Outstanding reads (FIFO + in flight) minus the entry leaving this edge
  // must stay below the FIFO depth, so a read can never overflow it.
  assign pop         = bus.rsp_vld & bus.rsp_rdy;
  assign credit_used = {1'b0, fifo_cnt} + (CNT_W+1)'(rd_vld_p1) - (CNT_W+1)'(pop);
  assign bus.req_rdy = ~RST & run & (bus.req_wr | (credit_used < DEPTH_C));
  assign acc_p0      = bus.req_vld & bus.req_rdy;
  assign rd_acc_p0   = acc_p0 & ~bus.req_wr;

  // Drive SRAM pins straight from the request in the accept cycle.
  always_comb begin
    sram_a   = bus.req_addr;
    sram_d   = bus.req_wdata;
    sram_cen = ~acc_p0;
    sram_wen = (acc_p0 & bus.req_wr) ? ~bus.req_be : {BE_W{1'b1}};
`ifdef SPSRAM_CTRL_INIT_EN
    if (init_wr) begin
      sram_a   = init_addr;
      sram_d   = '0;
      sram_cen = 1'b0;
      sram_wen = '0;
    end
`endif
  end

  // ---- p1: SRAM Q valid, push into response FIFO ----
  // In-flight flag: Q of a read accepted last edge is valid this cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) rd_vld_p1 <= 1'b0;
    else     rd_vld_p1 <= rd_acc_p0;
  end

  // FIFO pointers and occupancy; power-of-two depth lets pointers wrap freely.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (rd_vld_p1) wr_ptr <= wr_ptr + 1'b1;
      if (pop)       rd_ptr <= rd_ptr + 1'b1;
      case ({rd_vld_p1, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // FIFO storage; contents are don't-care while the count says empty.
  always_ff @(posedge CLK) begin
    if (rd_vld_p1) fifo_mem[wr_ptr] <= sram_q;
  end

  // ---- p2: response presented from FIFO head ----
  assign bus.rsp_vld  = (fifo_cnt != '0);
  assign bus.rsp_data = fifo_mem[rd_ptr];
endmodule

// File: tb/tb_spsram_access_ctrl.sv
// Bench for spsram_access_ctrl: a behavioural SRAM array drives sram_q, and a
// request-level reference (shadow memory + ordered queue of expected reads)
// predicts every response, its timing and the credit-based ready.
module tb_spsram_access_ctrl;
`ifdef SPSRAM_CTRL_INIT_EN
  localparam int AW = 4;
`else
  localparam int AW = 21;
`endif
  localparam int DW    = 128;
  localparam int BW    = DW / 8;
  localparam int DEPTH = 2;
  localparam logic [DW-1:0] PAT = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [AW-1:0] A10 = AW'(32'h10);

  logic          CLK = 1'b0;
  logic          RST;
  logic [AW-1:0] sram_a;
  logic          sram_cen;
  logic [BW-1:0] sram_wen;
  logic [DW-1:0] sram_d;
  logic [DW-1:0] sram_q = '0;
  logic          init_done;

  spsram_access_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  spsram_access_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RSP_DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .bus(bus), .sram_a(sram_a), .sram_cen(sram_cen),
    .sram_wen(sram_wen), .sram_d(sram_d), .sram_q(sram_q), .init_done(init_done)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  typedef struct { logic [DW-1:0] data; int acc_cyc; } exp_t;
  exp_t          exp_q[$];
  logic [DW-1:0] shadow [logic [AW-1:0]];
  logic [DW-1:0] mem    [logic [AW-1:0]];

  // Behavioural single-port SRAM: read or byte-masked write per enabled edge.
  always @(posedge CLK) begin : sram_model
    logic [DW-1:0] m;
    if (sram_cen === 1'b0) begin
      m = mem.exists(sram_a) ? mem[sram_a] : '0;
      if (&sram_wen) sram_q <= m;
      else begin
        for (int b = 0; b < BW; b++) if (!sram_wen[b]) m[b*8 +: 8] = sram_d[b*8 +: 8];
        mem[sram_a] = m;
      end
    end
  end

  // One clock of traffic with the reference model checking every cycle.
  task automatic step(input bit vld, input bit wr, input logic [AW-1:0] addr,
                      input logic [DW-1:0] wd, input logic [BW-1:0] be, input bit rr,
                      output bit acc, output logic obs_vld, output logic [DW-1:0] obs_data,
                      output logic [BW-1:0] obs_wen);
    bit            exp_vld, pop, exp_rdy;
    int            outst;
    logic [DW-1:0] cur;
    logic [BW-1:0] exp_wen;
    @(negedge CLK);
    bus.req_vld = vld; bus.req_wr = wr; bus.req_addr = addr;
    bus.req_wdata = wd; bus.req_be = be; bus.rsp_rdy = rr;
    #1;
    obs_vld = bus.rsp_vld; obs_data = bus.rsp_data; obs_wen = sram_wen;
    exp_vld = (exp_q.size() > 0) && (exp_q[0].acc_cyc + 2 <= cyc);
    n_chk++;
    if (bus.rsp_vld !== exp_vld) begin
      n_fail++; $display("FAIL rsp_vld cyc=%0d got=%b exp=%b", cyc, bus.rsp_vld, exp_vld);
    end
    if (exp_vld) begin
      n_chk++;
      if (bus.rsp_data !== exp_q[0].data) begin
        n_fail++; $display("FAIL rsp_data cyc=%0d got=%h exp=%h", cyc, bus.rsp_data, exp_q[0].data);
      end
    end
    pop   = exp_vld && rr;
    outst = exp_q.size() - (pop ? 1 : 0);
    if (vld && (wr || !pop)) begin
      exp_rdy = wr || (outst < DEPTH);
      n_chk++;
      if (bus.req_rdy !== exp_rdy) begin
        n_fail++; $display("FAIL req_rdy cyc=%0d got=%b exp=%b", cyc, bus.req_rdy, exp_rdy);
      end
    end
    acc = vld && (bus.req_rdy === 1'b1);
    n_chk++;
    if (sram_cen !== !acc) begin
      n_fail++; $display("FAIL sram_cen cyc=%0d got=%b exp=%b", cyc, sram_cen, !acc);
    end
    exp_wen = (acc && wr) ? ~be : {BW{1'b1}};
    n_chk++;
    if (sram_wen !== exp_wen) begin
      n_fail++; $display("FAIL sram_wen cyc=%0d got=%h exp=%h", cyc, sram_wen, exp_wen);
    end
    if (acc) begin
      n_chk++;
      if (sram_a !== addr) begin
        n_fail++; $display("FAIL sram_a cyc=%0d got=%h exp=%h", cyc, sram_a, addr);
      end
      if (wr) begin
        n_chk++;
        if (sram_d !== wd) begin
          n_fail++; $display("FAIL sram_d cyc=%0d got=%h exp=%h", cyc, sram_d, wd);
        end
      end
    end
    if (pop) exp_q.delete(0);
    if (acc) begin
      cur = shadow.exists(addr) ? shadow[addr] : '0;
      if (wr) begin
        for (int b = 0; b < BW; b++) if (be[b]) cur[b*8 +: 8] = wd[b*8 +: 8];
        shadow[addr] = cur;
      end else begin
        exp_q.push_back('{data: cur, acc_cyc: cyc});
      end
    end
    cyc++;
  endtask

  task automatic idle(input bit rr, output logic v, output logic [DW-1:0] d);
    bit a; logic [BW-1:0] w;
    step(1'b0, 1'b0, '0, '0, '0, rr, a, v, d, w);
  endtask

  task automatic drain();
    logic v; logic [DW-1:0] d;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) idle(1'b1, v, d);
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL drain_timeout left=%0d exp=0", exp_q.size());
    end
  endtask

  // After reset release: zero-fill sequence if enabled, else immediate readiness.
  task automatic wait_init();
`ifdef SPSRAM_CTRL_INIT_EN
    int writes = 0, first_w = -1, last_w = -1, done_i = -1;
    bus.req_vld = 1'b1; bus.req_wr = 1'b1; bus.req_be = '1;
    bus.req_wdata = '1; bus.req_addr = '0; bus.rsp_rdy = 1'b1;
    for (int i = 0; i < 200 && done_i < 0; i++) begin
      @(negedge CLK); #1;
      if (init_done === 1'b1) begin
        done_i = i; bus.req_vld = 1'b0;
      end else begin
        n_chk++;
        if (bus.req_rdy !== 1'b0) begin
          n_fail++; $display("FAIL init_req_rdy got=%b exp=0", bus.req_rdy);
        end
        if (sram_cen === 1'b0) begin
          n_chk++;
          if (sram_a !== AW'(writes) || sram_wen !== '0 || sram_d !== '0) begin
            n_fail++;
            $display("FAIL init_write a=%h wen=%h d=%h exp a=%h wen=0 d=0", sram_a, sram_wen, sram_d, AW'(writes));
          end
          if (first_w < 0) first_w = i;
          last_w = i; writes++;
        end
      end
    end
    bus.req_vld = 1'b0;
    n_chk++;
    if (done_i < 0) begin n_fail++; $display("FAIL init_timeout got=0 exp=1"); end
    n_chk++;
    if (writes != (1 << AW)) begin n_fail++; $display("FAIL init_count got=%0d exp=%0d", writes, 1 << AW); end
    n_chk++;
    if (last_w - first_w + 1 != writes || done_i != last_w + 1) begin
      n_fail++; $display("FAIL init_timing first=%0d last=%0d done=%0d", first_w, last_w, done_i);
    end
    shadow.delete();
`else
    #1;
    n_chk++;
    if (init_done !== 1'b1) begin n_fail++; $display("FAIL init_done got=%b exp=1", init_done); end
`endif
  endtask

  task automatic test_reset();
    RST = 1'b1;
    bus.req_vld = 1'b1; bus.req_wr = 1'b1; bus.req_addr = '0;
    bus.req_wdata = '1; bus.req_be = '1; bus.rsp_rdy = 1'b0;
    #3;
    n_chk++;
    if (bus.req_rdy !== 1'b0 || bus.rsp_vld !== 1'b0 || sram_cen !== 1'b1 || sram_wen !== {BW{1'b1}}) begin
      n_fail++;
      $display("FAIL reset_outputs rdy=%b vld=%b cen=%b wen=%h exp 0 0 1 all-ones", bus.req_rdy, bus.rsp_vld, sram_cen, sram_wen);
    end
    n_chk++;
`ifdef SPSRAM_CTRL_INIT_EN
    if (init_done !== 1'b0) begin n_fail++; $display("FAIL reset_init_done got=%b exp=0", init_done); end
`else
    if (init_done !== 1'b1) begin n_fail++; $display("FAIL reset_init_done got=%b exp=1", init_done); end
`endif
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    bus.req_vld = 1'b0;
    RST = 1'b0;
    wait_init();
  endtask

  task automatic test_first_read();
    bit a; logic v; logic [DW-1:0] d; logic [BW-1:0] w;
    step(1'b1, 1'b0, AW'(7), '0, '0, 1'b1, a, v, d, w);
    idle(1'b1, v, d);
    idle(1'b1, v, d);
    n_chk++;
    if (v !== 1'b1 || d !== '0) begin n_fail++; $display("FAIL first_read vld=%b data=%h exp 1 0", v, d); end
  endtask

  task automatic test_write_read();
    bit a; logic v; logic [DW-1:0] d; logic [BW-1:0] w;
    step(1'b1, 1'b1, A10, PAT, '1, 1'b1, a, v, d, w);
    n_chk++;
    if (!a || w !== 16'h0000) begin n_fail++; $display("FAIL full_write acc=%b wen=%h exp 1 0000", a, w); end
    step(1'b1, 1'b0, A10, '0, '0, 1'b1, a, v, d, w);
    idle(1'b1, v, d);
    n_chk++;
    if (v !== 1'b0) begin n_fail++; $display("FAIL latency_early vld=%b exp=0", v); end
    idle(1'b1, v, d);
    n_chk++;
    if (v !== 1'b1 || d !== PAT) begin n_fail++; $display("FAIL latency_data vld=%b data=%h exp 1 %h", v, d, PAT); end
  endtask

  task automatic test_byte_write();
    bit a; logic v; logic [DW-1:0] d, e; logic [BW-1:0] w;
    e = PAT; e[7:0] = 8'hAA;
    step(1'b1, 1'b1, A10, {BW{8'hAA}}, 16'h0001, 1'b1, a, v, d, w);
    n_chk++;
    if (w !== 16'hFFFE) begin n_fail++; $display("FAIL byte_wen got=%h exp=fffe", w); end
    step(1'b1, 1'b0, A10, '0, '0, 1'b1, a, v, d, w);
    idle(1'b1, v, d);
    idle(1'b1, v, d);
    n_chk++;
    if (v !== 1'b1 || d !== e) begin n_fail++; $display("FAIL byte_merge data=%h exp=%h", d, e); end
  endtask

  task automatic test_backpressure();
    bit a; logic v; logic [DW-1:0] d; logic [BW-1:0] w;
    int accepted = 0, pops = 0;
    for (int i = 1; i <= 4; i++)
      step(1'b1, 1'b1, AW'(i), {$urandom, $urandom, $urandom, $urandom}, '1, 1'b0, a, v, d, w);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, AW'(accepted + 1), '0, '0, 1'b0, a, v, d, w);
      if (i == 2) begin
        n_chk++;
        if (a) begin n_fail++; $display("FAIL credit_stall acc=%b exp=0", a); end
      end
      if (a) accepted++;
    end
    n_chk++;
    if (accepted != 2) begin n_fail++; $display("FAIL credit_accepts got=%0d exp=2", accepted); end
    for (int i = 0; i < 40 && (accepted < 4 || exp_q.size() > 0); i++) begin
      step(accepted < 4, 1'b0, AW'(accepted + 1), '0, '0, 1'b1, a, v, d, w);
      if (a) accepted++;
      if (v === 1'b1) pops++;
    end
    n_chk++;
    if (accepted != 4 || pops != 4) begin
      n_fail++; $display("FAIL bp_responses accepted=%0d pops=%0d exp 4 4", accepted, pops);
    end
  endtask

  task automatic test_write_while_stalled();
    bit a; logic v; logic [DW-1:0] d, wd; logic [BW-1:0] w;
    step(1'b1, 1'b0, AW'(2), '0, '0, 1'b0, a, v, d, w);
    step(1'b1, 1'b0, AW'(3), '0, '0, 1'b0, a, v, d, w);
    idle(1'b0, v, d);
    idle(1'b0, v, d);
    step(1'b1, 1'b0, AW'(4), '0, '0, 1'b0, a, v, d, w);
    n_chk++;
    if (a) begin n_fail++; $display("FAIL full_read_acc got=%b exp=0", a); end
    wd = {$urandom, $urandom, $urandom, $urandom};
    step(1'b1, 1'b1, AW'(5), wd, '1, 1'b0, a, v, d, w);
    n_chk++;
    if (!a || w !== 16'h0000) begin n_fail++; $display("FAIL stalled_write acc=%b wen=%h exp 1 0000", a, w); end
    drain();
    step(1'b1, 1'b0, AW'(5), '0, '0, 1'b1, a, v, d, w);
    drain();
  endtask

  task automatic test_back_to_back();
    bit a; logic v; logic [DW-1:0] d; logic [BW-1:0] w;
    int accepted = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, AW'(i % 8), '0, '0, 1'b1, a, v, d, w);
      if (a) accepted++;
    end
    n_chk++;
    if (accepted != 8) begin n_fail++; $display("FAIL throughput got=%0d exp=8", accepted); end
    drain();
  endtask

  task automatic test_random();
    bit a; logic v; logic [DW-1:0] d; logic [BW-1:0] w;
    for (int i = 0; i < 400; i++)
      step(($urandom % 4) != 0, $urandom % 2, AW'($urandom % 8),
           {$urandom, $urandom, $urandom, $urandom}, BW'($urandom), ($urandom % 4) != 0, a, v, d, w);
    drain();
  endtask

  task automatic test_reset_midop();
    bit a; logic v; logic [DW-1:0] d; logic [BW-1:0] w;
    step(1'b1, 1'b0, AW'(1), '0, '0, 1'b0, a, v, d, w);
    step(1'b1, 1'b0, AW'(2), '0, '0, 1'b0, a, v, d, w);
    @(negedge CLK);
    bus.req_vld = 1'b1; bus.req_wr = 1'b0; bus.rsp_rdy = 1'b0;
    #1;
    n_chk++;
    if (bus.rsp_vld !== 1'b1) begin n_fail++; $display("FAIL pre_reset_vld got=%b exp=1", bus.rsp_vld); end
    RST = 1'b1;
    #1;
    n_chk++;
    if (bus.req_rdy !== 1'b0 || bus.rsp_vld !== 1'b0 || sram_cen !== 1'b1 || sram_wen !== {BW{1'b1}}) begin
      n_fail++;
      $display("FAIL async_reset rdy=%b vld=%b cen=%b wen=%h exp 0 0 1 all-ones", bus.req_rdy, bus.rsp_vld, sram_cen, sram_wen);
    end
    exp_q.delete();
    bus.req_vld = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    wait_init();
    for (int i = 0; i < 6; i++) begin
      idle(1'b1, v, d);
      n_chk++;
      if (v !== 1'b0) begin n_fail++; $display("FAIL post_reset_vld cyc=%0d got=%b exp=0", i, v); end
    end
    step(1'b1, 1'b0, AW'(3), '0, '0, 1'b1, a, v, d, w);
    drain();
  endtask

  initial begin
`ifdef SPSRAM_CTRL_INIT_EN
    for (int k = 0; k < (1 << AW); k++) mem[AW'(k)] = {$urandom, $urandom, $urandom, 32'h1};
`endif
    test_reset();
    test_first_read();
    test_write_read();
    test_byte_write();
    test_backpressure();
    test_write_while_stalled();
    test_back_to_back();
    test_random();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, exp finish before 2ms");
    $fatal(1, "watchdog");
  end
endmodule
